// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point multiply/divide datapath.
// Holds the state encoding, the default Q format, and a Q-format helper.
package fxp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fxp_state_e;

  localparam int unsigned DefWidth = 10;
  localparam int unsigned DefFrac  = 5;

  // Representation of 1.0 in the default format.
  localparam int unsigned FxpOne = 1 << DefFrac;

  function automatic int unsigned fxp_one(input int unsigned frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/fxp_step_counter.sv
// Iteration counter with synchronous clear, enable and a terminal-count flag.
// Shared by the multiplier and divider sequencers.
module fxp_step_counter #(
  parameter int unsigned CntW  = 4,
  parameter int unsigned TcVal = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [CntW-1:0] o_cnt,
  output logic            o_tc
);

  localparam logic [CntW-1:0] TcCnt = CntW'(TcVal);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TcCnt);

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned fixed-point shift-add multiplier: P = (A*B) >> FRAC.
// One partial product per clock; shares the ld_a/ld_b/start handshake with the divider.
module fixed_point_multiplier
  import fxp_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned FRAC  = DefFrac
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P,
  output logic             ov
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  fxp_state_e         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_step;
  logic               w_tc;
  logic [CntW-1:0]    w_cnt;

  assign w_accept = (r_state == StIdle) && start;
  assign w_step   = (r_state == StRun);

  fxp_step_counter #(
    .CntW  (CntW),
    .TcVal (WIDTH - 1)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_step),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (ld_a) r_a <= A;
          if (ld_b) r_b <= B;
          // Operands latch from r_a/r_b, so a same-edge load affects only the next run.
          if (start) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, r_a};
            r_mplr  <= r_b;
            r_state <= StRun;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (r_mplr[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          if (w_tc) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_acc[FRAC +: WIDTH];
  assign ov   = |r_acc[2*WIDTH-1:FRAC+WIDTH];

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier: directed steps with a
// result scoreboard filled at start and drained at each done pulse.
module tb_fixed_point_multiplier;

  localparam int unsigned W  = 10;
  localparam int unsigned FR = 5;

  typedef struct packed {
    logic [W-1:0] p;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld_a = 1'b0;
  logic         ld_b = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] P;
  logic         ov;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb_q[$];
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  fixed_point_multiplier #(
    .WIDTH (W),
    .FRAC  (FR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ld_a  (ld_a),
    .ld_b  (ld_b),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pr;
    res_t r;
    pr   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r.p  = pr[FR +: W];
    r.ov = |(pr >> (FR + W));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ld_a = 1'b1; ld_b = 1'b1; A = a; B = b;
    m_a = a; m_b = b;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded) and checks the count.
  task automatic wait_done(input string tag, input int exp_edges);
    int edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (done !== 1'b1) check({tag, "_busy"}, busy, 1'b1);
    end
    check({tag, "_latency"}, edges, exp_edges);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_P"}, P, e.p);
      check({tag, "_ov"}, ov, e.ov);
    end
  endtask

  // Start one run, optionally disturbing it with start/ld_a mid-RUN.
  task automatic run_op(input string tag, input bit disturb);
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(model(m_a, m_b));
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      repeat (2) @(negedge clk);
      start = 1'b1; ld_a = 1'b1; A = 10'b0000100000;
      @(negedge clk);
      start = 1'b0; ld_a = 1'b0;
      wait_done(tag, 7);
    end else begin
      wait_done(tag, 10);
    end
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    res_t hold;

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_P", P, '0);
    check("rst_ov", ov, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic: 3.0 * 2.5 = 7.5
    load(10'b0001100000, 10'b0001010000);
    run_op("basic", 1'b0);
    check("basic_const", P, 10'b0011110000);

    // Overflow
    load(10'b1010000000, 10'b0001000000);
    run_op("ovf_20x2", 1'b0);
    load(10'b1111111111, 10'b1111111111);
    run_op("ovf_max", 1'b0);
    check("ovf_max_const", {ov, P}, {1'b1, 10'b1111000000});

    // Truncation and zero operand
    load(10'b0000000001, 10'b0000010000);
    run_op("trunc", 1'b0);
    load(10'b0000000000, 10'b1111111111);
    run_op("zero", 1'b0);

    // Ignored controls mid-RUN; a later run proves A_r kept its value
    load(10'b0001100000, 10'b0001010000);
    run_op("ignore", 1'b1);
    run_op("retain", 1'b0);
    check("retain_const", P, 10'b0011110000);

    // Asynchronous reset at step 5
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_P", P, '0);
    check("mid_rst_ov", ov, 1'b0);
    sb_q.delete();
    m_a = '0; m_b = '0;
    @(negedge clk);
    rst = 1'b0;
    load(10'b0001100000, 10'b0001010000);
    run_op("post_rst", 1'b0);

    // Back-to-back with start held high (1.5 * 2.0 = 3.0)
    load(10'b0000110000, 10'b0001000000);
    hold = model(m_a, m_b);
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(hold);
    sb_q.push_back(hold);
    @(negedge clk);
    wait_done("b2b1", 10);
    check_result("b2b1");
    @(negedge clk);
    check("b2b_gap_busy", busy, 1'b0);
    check("b2b_gap_P", P, hold.p);
    wait_done("b2b2", 11);
    start = 1'b0;
    check_result("b2b2");
    @(negedge clk);
    check("b2b_end_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_P", P, hold.p);
    check("hold_ov", ov, hold.ov);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplier.md
Name: fixed_point_multiplier

Overview:
- Sequential unsigned fixed-point shift-add multiplier; the inverse-operation companion to the fixed-point divider in the same datapath.
- Operands are loaded through the same ld_a/ld_b/start handshake as the divider, so a controller can drive either unit interchangeably.
- Computes P = (A*B) >> FRAC, one partial product per clock, with a constant latency.
- Flags overflow when the product's integer part does not fit.

Parameters:
- WIDTH, 10, operand and result width in bits.
- FRAC, 5, number of fractional bits (default format Q5.5); legal range 0..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ld_a  input  1  load A into operand register A_r; honoured only in IDLE
- ld_b  input  1  load B into operand register B_r; honoured only in IDLE
- A  input  WIDTH  multiplicand, unsigned QI.F
- B  input  WIDTH  multiplier, unsigned QI.F
- start  input  1  begin multiply; sampled only in IDLE
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; P and ov are valid from this cycle on
- P  output  WIDTH  product: acc[FRAC+WIDTH-1:FRAC], truncated, not rounded
- ov  output  1  OR of acc[2*WIDTH-1:FRAC+WIDTH]

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - state=IDLE.
  - A_r, B_r, acc, mcand, mplr and cnt all cleared.
  - busy=0, done=0, P=0, ov=0.
- Operand loading:
  - In IDLE, ld_a/ld_b capture A/B on the rising edge. Both may be asserted together; each is independent.
  - Asserted in RUN or DONE, they are ignored.
- States: IDLE, RUN, DONE. Moore outputs: busy=(state!=IDLE), done=(state==DONE).
- IDLE:
  - On an edge with start=1: acc<=0, mcand<={WIDTH zeros, A_r} (2*WIDTH bits), mplr<=B_r, cnt<=0, go to RUN.
  - If ld_a and start are asserted on the same edge, the OLD A_r is used; same rule for ld_b.
- RUN, each edge:
  - if mplr[0], acc<=acc+mcand.
  - mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 the step still executes and the next state is DONE.
  - Exactly WIDTH steps, no early exit on zero operands.
- DONE: lasts one cycle, then IDLE unconditionally. start during DONE is ignored.
- Timing:
  - start sampled at edge t0; accumulate steps at edges t1..tWIDTH; done high from tWIDTH to tWIDTH+1.
  - Latency is WIDTH+1 edges (11 for the default).
  - Back-to-back: start may be accepted on the edge after done falls (earliest t(WIDTH+2)).
- Result hold: P and ov are combinational slices of acc. They stay stable after done until the next accepted start clears acc; they may transition during RUN.
- Arithmetic: acc is 2*WIDTH bits wide and cannot wrap, since max product (2^WIDTH-1)^2 < 2^(2*WIDTH). The fraction below FRAC is discarded; no rounding, no saturation. On overflow, P is the wrapped low slice.
- cnt width: $clog2(WIDTH); when WIDTH is a power of two it still terminates at WIDTH-1.
- start asserted while busy: ignored entirely; no queuing, no error flag.

Decomposition:
- Shared package fxp_pkg: state enum (IDLE/RUN/DONE), default WIDTH/FRAC constants, and the Q-format helper constant ONE = 1<<FRAC. The divider uses the same package.
- Optional sub-module fxp_step_counter: the cnt register with clear, enable and terminal-count output (tc at WIDTH-1). Reusable by the divider's iteration counter.
- Datapath and FSM otherwise stay in one module.

Test Plan:
- Basic: rst pulse; ld_a with A=0001100000 (3.0), ld_b with B=0001010000 (2.5); start -> busy for 11 edges, done pulses exactly once at t10..t11, P=0011110000 (7.5), ov=0.
- Overflow: A=1010000000 (20.0), B=0001000000 (2.0) -> P=0100000000, ov=1. Then A=B=1111111111 -> P=1111000000, ov=1.
- Truncation/zero: A=0000000001, B=0000010000 -> P=0, ov=0. A=0, B=1111111111 -> P=0, ov=0, still 11-edge latency.
- Ignored controls: start re-asserted and ld_a pulsed with A=0000100000 mid-RUN -> no restart, result unchanged; a later run shows A_r retained the old value.
- Reset mid-operation: assert rst at step 5, asynchronous to the clock edge -> busy, done, P and ov go to 0 immediately; after release a fresh load/start gives the correct 7.5 result.
- Back-to-back and hold: start held high continuously -> runs repeat with period WIDTH+2 edges; P stays stable through the IDLE gap after each done.
